pad_insert_filter: RTL

//  Inverse of the crop stage: accepts a streamed IN_ROWS x IN_COLS sub-image and

---
 rtl/pad_insert_filter.sv | 99 +++++++++
 1 files changed

// File: rtl/pad_insert_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pad_insert_filter                                                 |
// | Brief  : Embeds a streamed sub-image into a full frame of pad pixels.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module pad_insert_filter #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20,
  parameter int OUT_ROWS        = 40,
  parameter int OUT_COLS        = 40,
  parameter int Y_1             = 10,
  parameter int X_1             = 10,
  parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eof
);

  localparam int XW = $clog2(OUT_COLS + 1);
  localparam int YW = $clog2(OUT_ROWS + 1);

  localparam logic [XW-1:0] c_X_LO   = XW'(X_1);
  localparam logic [XW-1:0] c_X_HI   = XW'(X_1 + IN_COLS);
  localparam logic [XW-1:0] c_X_LAST = XW'(OUT_COLS - 1);
  localparam logic [YW-1:0] c_Y_LO   = YW'(Y_1);
  localparam logic [YW-1:0] c_Y_HI   = YW'(Y_1 + IN_ROWS);
  localparam logic [YW-1:0] c_Y_LAST = YW'(OUT_ROWS - 1);

  generate
    if ((Y_1 + IN_ROWS > OUT_ROWS) || (X_1 + IN_COLS > OUT_COLS)) begin : g_geom_err
      $error("pad_insert_filter: sub-image window does not fit inside the output frame");
    end
  endgenerate

  // r_x/r_y address the next pixel to be produced, not the one on pixel_out
  logic [XW-1:0]              r_x;
  logic [YW-1:0]              r_y;
  logic [PIXEL_BIT_WIDTH-1:0] r_pixel;
  logic                       r_valid;
  logic                       r_sof;
  logic                       r_eof;

  logic w_inside;
  logic w_load_en;
  logic w_produce;
  logic w_last_x;
  logic w_last_y;

  assign w_inside  = (r_y >= c_Y_LO) && (r_y < c_Y_HI) && (r_x >= c_X_LO) && (r_x < c_X_HI);
  assign w_load_en = !r_valid || out_ready;
  assign w_produce = w_load_en && (w_inside ? in_valid : 1'b1);
  assign w_last_x  = (r_x == c_X_LAST);
  assign w_last_y  = (r_y == c_Y_LAST);

  assign in_ready  = w_load_en && w_inside;
  assign pixel_out = r_pixel;
  assign out_valid = r_valid;
  assign out_sof   = r_sof;
  assign out_eof   = r_eof;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_pixel <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_load_en) begin
      if (w_produce) begin
        r_pixel <= w_inside ? pixel_in : PAD_VALUE;
        r_valid <= 1'b1;
        r_sof   <= (r_x == '0) && (r_y == '0);
        r_eof   <= w_last_x && w_last_y;
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end else begin
        // window pixel with no input available: bubble, position held
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
